reg_file_wb: RTL

- 32 x 32-bit register file with a one-entry registered write-back stage and a ZCV status register.
- Its two asynchronous read ports supply the ALU's src1/src2 operands.
- Its write port and flag inputs consume the ALU's result, zero, cout and overflow.
- The WB stage is forwarded onto the read ports, so back-to-back dependent ALU operations read correct operands.

---
 rtl/reg_file_wb_pkg.sv | 16 +
 rtl/reg_file_wb_read_mux.sv | 24 ++
 rtl/reg_file_wb.sv | 99 +++++++++
 3 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the register file with registered write-back stage.
// Flag bit positions follow the ALU's {zero, cout, overflow} ordering.
package reg_file_wb_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;
    localparam int RF_CNT_W  = 16;

    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    localparam int FLAG_W = 3;

endpackage

// File: rtl/reg_file_wb_read_mux.sv
// One read port: r0 reads zero, a pending write-back entry wins over the
// array copy so dependent back-to-back operations see the newest value.
module rf_read_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] array_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = array_data;
        if (addr == '0) begin
            data = '0;
        end else if (wb_valid && (wb_addr == addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 register file: writes pass through a one-entry write-back register
// before reaching the array, and that entry is forwarded onto both read ports.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              flag_we,
    input  logic              zero_in,
    input  logic              cout_in,
    input  logic              overflow_in,
    output logic [2:0]        flags_out,
    output logic              wb_busy,
    output logic [CNT_W-1:0]  commit_count
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [2:0]        flags_q;
    logic [CNT_W-1:0]  commit_q;
    logic              wr_accept;

    // Every write is accepted with no backpressure; only r0 targets are dropped.
    assign wr_accept = rd_we && (rd_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wr_accept;
            if (wr_accept) begin
                wb_addr <= rd_addr;
                wb_data <= rd_data;
            end
        end
    end

    // The commit uses the entry that was pending before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            commit_q <= '0;
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
            commit_q      <= commit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q[Z_BIT] <= zero_in;
            flags_q[C_BIT] <= cout_in;
            flags_q[V_BIT] <= overflow_in;
        end
    end

    rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .addr       (rs1_addr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .array_data (regs[rs1_addr]),
        .data       (rs1_data)
    );

    rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .addr       (rs2_addr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .array_data (regs[rs2_addr]),
        .data       (rs2_data)
    );

    assign flags_out    = flags_q;
    assign wb_busy      = wb_valid;
    assign commit_count = commit_q;

endmodule
